booth_mul_seq: RTL

- Parametrised sequential radix-2 Booth multiplier; next generation of the processing-in-memory 8-bit multiplier.
- Adds:
  - generic operand width
  - per-operation signed/unsigned mode
  - explicit busy/accept handshake
  - held product register
- Sits beside the PIM compute array.
- The controller issues one multiply at a time and waits for mul_done.

---
 rtl/booth_mul_seq.sv | 102 ++++++++++
 1 files changed

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier, one iteration per clock.
// Operands are widened by one bit so unsigned full-range inputs recode correctly.
module booth_mul_seq #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic [2*WIDTH-1:0] product,
    output logic               mul_done
);

    localparam int E = WIDTH + 1;

    logic [E-1:0]       a_q, a_d;
    logic [E-1:0]       q_q, q_d;
    logic [E-1:0]       m_q, m_d;
    logic               q1_q, q1_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic [E-1:0] mc_ext;
    logic [E-1:0] mp_ext;
    logic [E-1:0] sum;
    logic         last;

    assign mc_ext = {signed_mode & multiplicand[WIDTH-1], multiplicand};
    assign mp_ext = {signed_mode & multiplier[WIDTH-1], multiplier};
    assign last   = (cnt_q == CNT_W'(WIDTH));

    always_comb begin
        unique case ({q_q[0], q1_q})
            2'b01:   sum = a_q + m_q;
            2'b10:   sum = a_q - m_q;
            default: sum = a_q;
        endcase
    end

    always_comb begin
        a_d    = a_q;
        q_d    = q_q;
        m_d    = m_q;
        q1_d   = q1_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        prod_d = prod_q;
        if (busy_q) begin
            // Arithmetic shift of {sum, Q, Q_1}, replicating sum's MSB.
            a_d   = {sum[E-1], sum[E-1:1]};
            q_d   = {sum[0], q_q[E-1:1]};
            q1_d  = q_q[0];
            cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                prod_d = {sum[WIDTH-1:0], q_q[E-1:1]};
            end
        end else if (start) begin
            a_d    = '0;
            q_d    = mp_ext;
            m_d    = mc_ext;
            q1_d   = 1'b0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            q_q    <= '0;
            m_q    <= '0;
            q1_q   <= 1'b0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            prod_q <= '0;
        end else begin
            a_q    <= a_d;
            q_q    <= q_d;
            m_q    <= m_d;
            q1_q   <= q1_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            prod_q <= prod_d;
        end
    end

    assign busy     = busy_q;
    assign mul_done = done_q;
    assign product  = prod_q;

endmodule
